// File: rtl/slink_apb_pkg.sv
// Shared definitions for the S-Link APB requester arbiter.
// State encoding and default ACCESS-phase timeout.
package slink_apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DRAIN  = 2'd3
   } apb_state_t;

   localparam logic [15:0] TIMEOUT_DEFAULT = 16'd256;

endpackage

// File: rtl/slink_rr_arb.sv
// Combinational round-robin picker.
// Search starts one past the last winner and wraps at N.
module slink_rr_arb
   import slink_apb_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   last,
   output logic         gnt_valid,
   output logic [2:0]   gnt_idx
);

   always_comb begin
      logic [7:0] req_x;
      logic [2:0] idx;
      req_x     = 8'(req);
      idx       = '0;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      // Walk farthest-first so the nearest requester wins.
      for (int k = N; k >= 1; k--) begin
         idx = 3'((int'(last) + k) % N);
         if (req_x[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = idx;
         end
      end
   end

endmodule

// File: rtl/slink_apb_arb.sv
// N-to-1 APB requester arbiter in front of the S-Link APB tunnel.
// One transfer in flight; stalled ACCESS phases are timed out and drained.
module slink_apb_arb
   import slink_apb_pkg::*;
#(
   parameter int          NUM_MST = 2,
   parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                  apb_clk,
   input  logic                  apb_reset_n,
   input  logic                  enable,
   input  logic [NUM_MST-1:0]    s_apb_psel,
   input  logic [NUM_MST-1:0]    s_apb_penable,
   input  logic [NUM_MST-1:0]    s_apb_pwrite,
   input  logic [NUM_MST*32-1:0] s_apb_paddr,
   input  logic [NUM_MST*32-1:0] s_apb_pwdata,
   output logic [NUM_MST*32-1:0] s_apb_prdata,
   output logic [NUM_MST-1:0]    s_apb_pready,
   output logic [NUM_MST-1:0]    s_apb_pslverr,
   output logic                  m_apb_psel,
   output logic                  m_apb_penable,
   output logic                  m_apb_pwrite,
   output logic [31:0]           m_apb_paddr,
   output logic [31:0]           m_apb_pwdata,
   input  logic [31:0]           m_apb_prdata,
   input  logic                  m_apb_pready,
   input  logic                  m_apb_pslverr,
   output logic [2:0]            grant_id,
   output logic                  busy,
   output logic                  timeout_err,
   output logic [7:0]            timeout_cnt
);

   localparam logic [15:0] TO_LAST = TIMEOUT - 16'd1;

   apb_state_t  state;
   logic [2:0]  last_grant;
   logic [15:0] tcnt;
   logic        gnt_valid;
   logic [2:0]  gnt_idx;
   logic [7:0]  base;
   logic [7:0]  psel_x;
   logic [7:0]  pwrite_x;
   logic [255:0] paddr_x;
   logic [255:0] pwdata_x;
   logic        cpl;
   logic        to_fire;
   logic        unused_penable;

   assign unused_penable = ^s_apb_penable;
   assign psel_x   = 8'(s_apb_psel);
   assign pwrite_x = 8'(s_apb_pwrite);
   assign paddr_x  = 256'(s_apb_paddr);
   assign pwdata_x = 256'(s_apb_pwdata);
   assign base     = {gnt_idx, 5'b0};

   slink_rr_arb #(.N(NUM_MST)) u_rr (
      .req       (s_apb_psel),
      .last      (last_grant),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   assign cpl = (state == ST_ACCESS) && m_apb_pready;
   // A ready in the limit cycle wins over the timeout.
   assign to_fire = (TIMEOUT != 16'd0) && (state == ST_ACCESS)
                    && !m_apb_pready && (tcnt == TO_LAST);
   assign timeout_err = to_fire;

   always_ff @(posedge apb_clk or negedge apb_reset_n) begin
      if (!apb_reset_n) begin
         state         <= ST_IDLE;
         last_grant    <= 3'(NUM_MST - 1);
         grant_id      <= '0;
         tcnt          <= '0;
         timeout_cnt   <= '0;
         m_apb_psel    <= 1'b0;
         m_apb_penable <= 1'b0;
         m_apb_pwrite  <= 1'b0;
         m_apb_paddr   <= '0;
         m_apb_pwdata  <= '0;
         busy          <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (enable && gnt_valid) begin
                  state        <= ST_SETUP;
                  last_grant   <= gnt_idx;
                  grant_id     <= gnt_idx;
                  m_apb_paddr  <= paddr_x[base +: 32];
                  m_apb_pwdata <= pwdata_x[base +: 32];
                  m_apb_pwrite <= pwrite_x[gnt_idx];
                  m_apb_psel   <= 1'b1;
                  busy         <= 1'b1;
                  tcnt         <= '0;
               end
            end
            ST_SETUP: begin
               state         <= ST_ACCESS;
               m_apb_penable <= 1'b1;
            end
            ST_ACCESS: begin
               if (m_apb_pready) begin
                  state         <= ST_IDLE;
                  m_apb_psel    <= 1'b0;
                  m_apb_penable <= 1'b0;
                  busy          <= 1'b0;
               end else if (to_fire) begin
                  state <= ST_DRAIN;
                  if (timeout_cnt != 8'hFF)
                     timeout_cnt <= timeout_cnt + 8'd1;
               end else if (tcnt != 16'hFFFF) begin
                  tcnt <= tcnt + 16'd1;
               end
            end
            ST_DRAIN: begin
               if (m_apb_pready) begin
                  state         <= ST_IDLE;
                  m_apb_psel    <= 1'b0;
                  m_apb_penable <= 1'b0;
                  busy          <= 1'b0;
               end
            end
         endcase
      end
   end

   // Response goes only to the granted port, and only while it still selects.
   always_comb begin
      s_apb_pready  = '0;
      s_apb_pslverr = '0;
      s_apb_prdata  = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (grant_id == 3'(i) && psel_x[grant_id]) begin
            s_apb_pready[i]        = cpl | to_fire;
            s_apb_pslverr[i]       = cpl ? m_apb_pslverr : to_fire;
            s_apb_prdata[32*i +: 32] = cpl ? m_apb_prdata : 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_slink_apb_arb.sv
// Directed self-checking bench for slink_apb_arb.
// Two requester ports, TIMEOUT=8.
module tb_slink_apb_arb;

   logic        apb_clk = 1'b0;
   logic        apb_reset_n;
   logic        enable;
   logic [1:0]  s_psel, s_penable, s_pwrite;
   logic [63:0] s_paddr, s_pwdata;
   logic [63:0] s_prdata;
   logic [1:0]  s_pready, s_pslverr;
   logic        m_psel, m_penable, m_pwrite;
   logic [31:0] m_paddr, m_pwdata;
   logic [31:0] m_prdata;
   logic        m_pready, m_pslverr;
   logic [2:0]  grant_id;
   logic        busy, timeout_err;
   logic [7:0]  timeout_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 apb_clk = ~apb_clk;

   slink_apb_arb #(.NUM_MST(2), .TIMEOUT(16'd8)) dut (
      .apb_clk       (apb_clk),
      .apb_reset_n   (apb_reset_n),
      .enable        (enable),
      .s_apb_psel    (s_psel),
      .s_apb_penable (s_penable),
      .s_apb_pwrite  (s_pwrite),
      .s_apb_paddr   (s_paddr),
      .s_apb_pwdata  (s_pwdata),
      .s_apb_prdata  (s_prdata),
      .s_apb_pready  (s_pready),
      .s_apb_pslverr (s_pslverr),
      .m_apb_psel    (m_psel),
      .m_apb_penable (m_penable),
      .m_apb_pwrite  (m_pwrite),
      .m_apb_paddr   (m_paddr),
      .m_apb_pwdata  (m_pwdata),
      .m_apb_prdata  (m_prdata),
      .m_apb_pready  (m_pready),
      .m_apb_pslverr (m_pslverr),
      .grant_id      (grant_id),
      .busy          (busy),
      .timeout_err   (timeout_err),
      .timeout_cnt   (timeout_cnt)
   );

   task automatic tick();
      @(negedge apb_clk);
      #1;
   endtask

   task automatic do_reset();
      apb_reset_n = 1'b0;
      tick();
      tick();
      apb_reset_n = 1'b1;
   endtask

   task automatic wait_setup(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (m_psel && !m_penable) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Single-port transfer; downstream ready after `waits` ACCESS cycles.
   task automatic xfer(
      input  int          p,
      input  logic        wr,
      input  logic [31:0] addr,
      input  logic [31:0] wd,
      input  logic [31:0] rd,
      input  logic        err,
      input  int          waits,
      output logic        ok,
      output logic [2:0]  gid,
      output int          acc,
      output int          pulses,
      output logic [63:0] prd,
      output logic [1:0]  perr,
      output logic        stable,
      output logic        to_seen
   );
      gid = 0; acc = 0; pulses = 0; prd = 0;
      perr = 0; stable = 1; to_seen = 0;
      tick();
      s_psel[p] = 1'b1;
      s_pwrite[p] = wr;
      s_penable[p] = 1'b0;
      s_paddr[32*p +: 32] = addr;
      s_pwdata[32*p +: 32] = wd;
      wait_setup(ok);
      if (!ok) begin
         s_psel[p] = 1'b0;
         return;
      end
      gid = grant_id;
      s_penable[p] = 1'b1;
      for (int i = 0; i <= waits; i++) begin
         tick();
         if (!(m_psel && m_penable)) stable = 0;
         if (m_paddr !== addr || m_pwrite !== wr) stable = 0;
         if (wr && m_pwdata !== wd) stable = 0;
         acc++;
         m_prdata = rd;
         m_pslverr = err;
         m_pready = (i == waits);
         #1;
         if (s_pready != 2'b00) pulses++;
         if (timeout_err) to_seen = 1;
         if (i == waits) begin
            prd = s_prdata;
            perr = s_pslverr;
         end
      end
      tick();
      m_pready = 0; m_pslverr = 0; m_prdata = 0;
      s_psel[p] = 1'b0;
      s_penable[p] = 1'b0;
      #1;
      if (s_pready != 2'b00) pulses++;
   endtask

   logic        ok, stable, to_seen;
   logic [2:0]  gid;
   int          acc, pulses;
   logic [63:0] prd;
   logic [1:0]  perr;

   task automatic test_reset();
      apb_reset_n = 1'b0;
      enable = 1'b0;
      s_psel = 0; s_penable = 0; s_pwrite = 0;
      s_paddr = 0; s_pwdata = 0;
      m_prdata = 0; m_pready = 0; m_pslverr = 0;
      #3;
      n_cmp++;
      if ({m_psel, m_penable, m_pwrite} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_mctl got=%b want=000",
                  {m_psel, m_penable, m_pwrite});
      end
      n_cmp++;
      if (m_paddr !== 0 || m_pwdata !== 0) begin
         n_bad++;
         $display("FAIL reset_mdata got=%h/%h want=0", m_paddr, m_pwdata);
      end
      n_cmp++;
      if (s_pready !== 0 || s_pslverr !== 0 || s_prdata !== 0) begin
         n_bad++;
         $display("FAIL reset_s got=%b/%b/%h want=0",
                  s_pready, s_pslverr, s_prdata);
      end
      n_cmp++;
      if ({busy, timeout_err, grant_id, timeout_cnt} !== 13'd0) begin
         n_bad++;
         $display("FAIL reset_status got=%b/%b/%0d/%0d want=0",
                  busy, timeout_err, grant_id, timeout_cnt);
      end
      tick();
      tick();
      apb_reset_n = 1'b1;
      enable = 1'b1;
   endtask

   task automatic test_write();
      xfer(0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2,
           ok, gid, acc, pulses, prd, perr, stable, to_seen);
      n_cmp++;
      if (!ok || gid !== 3'd0) begin
         n_bad++;
         $display("FAIL wr_grant got=%b/%0d want=1/0", ok, gid);
      end
      n_cmp++;
      if (acc !== 3 || stable !== 1'b1) begin
         n_bad++;
         $display("FAIL wr_access got=%0d/%b want=3/1", acc, stable);
      end
      n_cmp++;
      if (pulses !== 1) begin
         n_bad++;
         $display("FAIL wr_pready_pulses got=%0d want=1", pulses);
      end
   endtask

   task automatic test_read_err();
      xfer(1, 1'b0, 32'h200, 32'h0, 32'h12345678, 1'b1, 1,
           ok, gid, acc, pulses, prd, perr, stable, to_seen);
      n_cmp++;
      if (!ok || gid !== 3'd1 || stable !== 1'b1) begin
         n_bad++;
         $display("FAIL rd_grant got=%b/%0d/%b want=1/1/1", ok, gid, stable);
      end
      n_cmp++;
      if (prd !== 64'h12345678_00000000) begin
         n_bad++;
         $display("FAIL rd_prdata got=%h want=1234567800000000", prd);
      end
      n_cmp++;
      if (perr !== 2'b10 || pulses !== 1) begin
         n_bad++;
         $display("FAIL rd_slverr got=%b/%0d want=10/1", perr, pulses);
      end
   endtask

   task automatic test_round_robin();
      logic [2:0] g;
      logic [2:0] want;
      do_reset();
      tick();
      s_psel = 2'b11;
      s_pwrite = 2'b00;
      for (int k = 0; k < 4; k++) begin
         wait_setup(ok);
         g = grant_id;
         want = 3'(k % 2);
         n_cmp++;
         if (!ok || g !== want) begin
            n_bad++;
            $display("FAIL rr_order[%0d] got=%b/%0d want=1/%0d",
                     k, ok, g, want);
         end
         tick();
         m_pready = 1'b1;
         tick();
         m_pready = 1'b0;
      end
      s_psel = 2'b00;
   endtask

   task automatic test_timeout();
      logic early, drain_bad, cnt_bad;
      early = 0; drain_bad = 0; cnt_bad = 0;
      tick();
      s_psel = 2'b01;
      s_paddr[31:0] = 32'h300;
      wait_setup(ok);
      s_penable[0] = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 2) s_psel[1] = 1'b1;
         m_prdata = 32'hAAAA5555;
         m_pready = (c == 20);
         #1;
         if (c < 8 && (s_pready != 0 || timeout_err)) early = 1;
         if (c == 8) begin
            n_cmp++;
            if (s_pready !== 2'b01 || s_pslverr !== 2'b01 ||
                s_prdata !== 64'h0 || timeout_err !== 1'b1) begin
               n_bad++;
               $display("FAIL to_fire got=%b/%b/%h/%b want=01/01/0/1",
                        s_pready, s_pslverr, s_prdata, timeout_err);
            end
            s_psel[0] = 1'b0;
            s_penable[0] = 1'b0;
         end
         if (c > 8) begin
            if (s_pready != 0 || !m_psel || !m_penable ||
                timeout_err || !busy || grant_id !== 3'd0)
               drain_bad = 1;
            if (timeout_cnt !== 8'd1) cnt_bad = 1;
         end
      end
      n_cmp++;
      if (early || drain_bad) begin
         n_bad++;
         $display("FAIL to_drain got=%b/%b want=0/0", early, drain_bad);
      end
      n_cmp++;
      if (cnt_bad) begin
         n_bad++;
         $display("FAIL to_count got=%0d want=1", timeout_cnt);
      end
      tick();
      m_pready = 1'b0;
      m_prdata = 0;
      n_cmp++;
      if (busy !== 1'b0 || m_psel !== 1'b0) begin
         n_bad++;
         $display("FAIL to_idle got=%b/%b want=0/0", busy, m_psel);
      end
      wait_setup(ok);
      n_cmp++;
      if (!ok || grant_id !== 3'd1) begin
         n_bad++;
         $display("FAIL to_next_grant got=%b/%0d want=1/1", ok, grant_id);
      end
      tick();
      m_pready = 1'b1;
      tick();
      m_pready = 1'b0;
      s_psel = 2'b00;
   endtask

   task automatic test_precedence();
      xfer(0, 1'b0, 32'h400, 32'h0, 32'h0BADF00D, 1'b0, 7,
           ok, gid, acc, pulses, prd, perr, stable, to_seen);
      n_cmp++;
      if (!ok || to_seen !== 1'b0 || perr !== 2'b00 || acc !== 8) begin
         n_bad++;
         $display("FAIL prec_no_timeout got=%b/%b/%b/%0d want=1/0/00/8",
                  ok, to_seen, perr, acc);
      end
      n_cmp++;
      if (prd !== 64'h0BADF00D || timeout_cnt !== 8'd1) begin
         n_bad++;
         $display("FAIL prec_data got=%h/%0d want=0badf00d/1",
                  prd, timeout_cnt);
      end
   endtask

   task automatic test_enable();
      logic bad;
      bad = 0;
      tick();
      s_psel = 2'b01;
      wait_setup(ok);
      s_penable[0] = 1'b1;
      tick();
      enable = 1'b0;
      s_psel[1] = 1'b1;
      tick();
      m_pready = 1'b1;
      #1;
      n_cmp++;
      if (s_pready !== 2'b01) begin
         n_bad++;
         $display("FAIL en_complete got=%b want=01", s_pready);
      end
      s_psel[0] = 1'b0;
      s_penable[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         m_pready = 1'b0;
         if (busy || m_psel) bad = 1;
      end
      n_cmp++;
      if (bad) begin
         n_bad++;
         $display("FAIL en_blocked got=1 want=0");
      end
      enable = 1'b1;
      wait_setup(ok);
      n_cmp++;
      if (!ok || grant_id !== 3'd1) begin
         n_bad++;
         $display("FAIL en_resume got=%b/%0d want=1/1", ok, grant_id);
      end
      tick();
      m_pready = 1'b1;
      tick();
      m_pready = 1'b0;
      s_psel = 2'b00;
   endtask

   task automatic test_reset_mid();
      tick();
      s_psel = 2'b10;
      s_paddr[63:32] = 32'h500;
      wait_setup(ok);
      tick();
      s_psel = 2'b11;
      apb_reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({m_psel, m_penable, busy} !== 3'b000 || m_paddr !== 0) begin
         n_bad++;
         $display("FAIL rst_mid_m got=%b%b%b/%h want=000/0",
                  m_psel, m_penable, busy, m_paddr);
      end
      n_cmp++;
      if (s_pready !== 0 || grant_id !== 0 || timeout_cnt !== 0) begin
         n_bad++;
         $display("FAIL rst_mid_status got=%b/%0d/%0d want=0/0/0",
                  s_pready, grant_id, timeout_cnt);
      end
      tick();
      apb_reset_n = 1'b1;
      wait_setup(ok);
      n_cmp++;
      if (!ok || grant_id !== 3'd0) begin
         n_bad++;
         $display("FAIL rst_mid_first got=%b/%0d want=1/0", ok, grant_id);
      end
      tick();
      m_pready = 1'b1;
      tick();
      m_pready = 1'b0;
      s_psel = 2'b00;
   endtask

   task automatic test_back_to_back();
      int cnt;
      logic g0, g1;
      cnt = 0;
      tick();
      s_psel = 2'b01;
      wait_setup(ok);
      g0 = (grant_id == 3'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         cnt++;
         m_pready = m_psel && m_penable;
         #1;
         if (m_psel && !m_penable) break;
      end
      g1 = (grant_id == 3'd0);
      n_cmp++;
      if (cnt !== 3 || !ok || !g0 || !g1) begin
         n_bad++;
         $display("FAIL b2b_spacing got=%0d/%b%b%b want=3/111",
                  cnt, ok, g0, g1);
      end
      tick();
      m_pready = 1'b1;
      tick();
      m_pready = 1'b0;
      s_psel = 2'b00;
      tick();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_err();
      test_round_robin();
      test_timeout();
      test_precedence();
      test_enable();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
